// File: rtl/df_sign_accumulator.sv
`timescale 1ns/1ps
// Sign-mask FIR core: a TAPS-deep delay line whose taps are summed or subtracted one per clock.
// Latency: acceptance at edge E0 -> result_valid pulse in the cycle after edge E0+TAPS.
// Backpressure: sample_ready is high only in IDLE; samples offered while busy are ignored, not queued.
module df_sign_accumulator #(
  parameter int WIDTH = 9,
  parameter int TAPS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [TAPS-1:0]  sign_mask,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] taps [TAPS];
  logic [TAPS-1:0]  mask_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] cur_tap;
  logic             cur_sub;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] sum;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake decode.
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    accept       = 1'b0;
    last         = 1'b0;
    case (state)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (cnt == CW'(TAPS - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add/subtract of the current tap; subtraction is a + ~b + 1, wrapping at WIDTH bits.
  always_comb begin
    cur_tap = taps[cnt];
    cur_sub = mask_q[cnt];
    operand = cur_sub ? ~cur_tap : cur_tap;
    sum     = acc + operand + {{(WIDTH-1){1'b0}}, cur_sub};
  end

  // Delay line: tap0 takes the newest sample, older samples move one tap down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else if (accept) begin
      taps[0] <= sample_in;
      for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
    end
  end

  // Accumulator, tap counter, latched mask and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      mask_q       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= last;
      if (accept) begin
        acc    <= '0;
        cnt    <= '0;
        mask_q <= sign_mask;
      end else if (state == ACCUM) begin
        acc <= sum;
        cnt <= cnt + CW'(1);
        if (last) begin
          result <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_df_sign_accumulator.sv
`timescale 1ns/1ps
// Testbench for df_sign_accumulator: directed scenarios plus randomized samples vs. an arithmetic model.
// Latency: checks result_valid exactly TAPS edges after acceptance.
// Backpressure: drives junk sample_valid/sample_in/sign_mask while busy and expects it ignored.
module tb_df_sign_accumulator;

  localparam int WIDTH = 9;
  localparam int TAPS  = 4;
  localparam int MODV  = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic [TAPS-1:0]  sign_mask;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  int n_checks;
  int n_errors;

  // Reference state: delay line as plain integers, newest first.
  int dl [TAPS];
  int exp_result;

  df_sign_accumulator #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sign_mask    (sign_mask),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) dl[k] = 0;
    exp_result = 0;
  endfunction

  // Push a sample and return the signed sum of the taps, reduced modulo 2^WIDTH.
  function automatic int model_accept(input int s, input logic [TAPS-1:0] m);
    int total;
    for (int k = TAPS - 1; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = s;
    total = 0;
    for (int k = 0; k < TAPS; k++) total = m[k] ? total - dl[k] : total + dl[k];
    return ((total % MODV) + MODV) % MODV;
  endfunction

  // Called #1 after an edge. Offers a sample, follows it to completion and returns the DUT result.
  task automatic run_sample(input logic [WIDTH-1:0] s, input logic [TAPS-1:0] m, input bit hold,
                            output logic [WIDTH-1:0] got, output int waited);
    int want;
    sample_in    = s;
    sign_mask    = m;
    sample_valid = 1'b1;
    waited       = 0;
    while (!sample_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 32'(sample_ready), 32'd1);
    @(posedge clk);
    want = model_accept(int'(s), m);
    #1;
    for (int i = 0; i < TAPS; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check("busy_ready", 32'(sample_ready), 32'd0);
      check("busy_valid", 32'(result_valid), 32'd0);
      check("busy_result_hold", 32'(result), 32'(exp_result));
      sample_in    = WIDTH'($urandom);
      sign_mask    = TAPS'($urandom);
      sample_valid = hold ? 1'b1 : 1'($urandom);
    end
    @(posedge clk); #1;
    check("done_valid", 32'(result_valid), 32'd1);
    check("done_ready", 32'(sample_ready), 32'd1);
    check("done_result", 32'(result), 32'(want));
    exp_result   = want;
    got          = result;
    sample_valid = hold;
    sample_in    = s;
    sign_mask    = m;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_valid", 32'(result_valid), 32'd0);
      check("idle_result", 32'(result), 32'(exp_result));
      check("idle_ready", 32'(sample_ready), 32'd1);
    end
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    #1;
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [WIDTH-1:0] got;
  int               waited;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    sign_mask    = '0;
    #2;
    do_reset();

    // Basic accumulation across two samples.
    run_sample(9'd72, 4'b0000, 1'b0, got, waited);
    check("tp_72", 32'(got), 32'd72);
    idle_cycles(1);
    run_sample(9'd163, 4'b0000, 1'b0, got, waited);
    check("tp_235", 32'(got), 32'd235);
    idle_cycles(2);

    // Subtracted tap.
    do_reset();
    run_sample(9'd179, 4'b0000, 1'b0, got, waited);
    check("tp_179", 32'(got), 32'd179);
    run_sample(9'd58, 4'b0010, 1'b0, got, waited);
    check("tp_391", 32'(got), 32'd391);
    idle_cycles(1);

    // Wrap-around on add and on subtract.
    do_reset();
    run_sample(9'd400, 4'b0000, 1'b0, got, waited);
    run_sample(9'd400, 4'b0000, 1'b0, got, waited);
    check("tp_wrap_288", 32'(got), 32'd288);
    run_sample(9'd127, 4'b1111, 1'b0, got, waited);
    check("tp_wrap_97", 32'(got), 32'd97);
    idle_cycles(1);

    // Valid held continuously: back-to-back accepts exactly every TAPS+1 edges.
    do_reset();
    run_sample(9'd46, 4'b0000, 1'b1, got, waited);
    check("hs_first_wait", 32'(waited), 32'd0);
    check("hs_46", 32'(got), 32'd46);
    run_sample(9'd46, 4'b0000, 1'b1, got, waited);
    check("hs_second_wait", 32'(waited), 32'd0);
    check("hs_92", 32'(got), 32'd92);
    run_sample(9'd46, 4'b0000, 1'b0, got, waited);
    check("hs_third_wait", 32'(waited), 32'd0);
    check("hs_138", 32'(got), 32'd138);
    idle_cycles(1);

    // Reset in the middle of an operation.
    sample_in    = 9'd127;
    sign_mask    = 4'b0000;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    check("mid_busy", 32'(sample_ready), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_ready", 32'(sample_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(1);
    run_sample(9'd127, 4'b0000, 1'b0, got, waited);
    check("mid_after_127", 32'(got), 32'd127);

    // Randomized samples, masks, gaps and occasional back-to-back holds.
    for (int n = 0; n < 60; n++) begin
      logic [WIDTH-1:0] rs;
      logic [TAPS-1:0]  rm;
      bit               rh;
      rs = WIDTH'($urandom);
      rm = TAPS'($urandom);
      rh = ($urandom_range(0, 3) == 0);
      run_sample(rs, rm, rh, got, waited);
      if (!rh) idle_cycles($urandom_range(0, 3));
      else check("rnd_b2b_wait", 32'(waited), 32'd0);
    end
    sample_valid = 1'b0;
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
